pixel_pipeline_credit_ctrl: RTL and testbench

PIXEL_PIPELINE_CREDIT_CTRL -- requirements
Module: pixel_pipeline_credit_ctrl

---
 rtl/pixel_pipeline_credit_ctrl.sv | 131 +++++++++++++
 tb/tb_pixel_pipeline_credit_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pipeline_credit_ctrl.sv
// rtl/pixel_pipeline_credit_ctrl.sv - credit-based flow control around a fixed-latency pixel pipeline
// Credits cover words in the pipeline plus words in the output FIFO, so the FIFO never overflows in normal use.
module pixel_pipeline_credit_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int LATENCY    = 24,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                              aclk,
    input  logic                              resetn,

    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,

    output logic                              pipe_in_valid,
    output logic                              pipe_in_last,
    output logic [DATA_WIDTH-1:0]             pipe_in_data,

    input  logic                              pipe_out_valid,
    input  logic                              pipe_out_last,
    input  logic [DATA_WIDTH-1:0]             pipe_out_data,

    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,

    input  logic                              flush_req,
    output logic                              flush_done,
    output logic                              pixelInPipeline,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   reserved_count,
    output logic                              overflow_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_params
        $error("pixel_pipeline_credit_ctrl: FIFO_DEPTH must be a power of two >= 2 and LATENCY >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   rd_en;
    logic                   wr_en;
    logic                   accept;
    logic                   tready_q;
    logic [CW-1:0]          count_nxt;

    assign s_axis_tready   = tready_q;
    assign accept          = s_axis_tvalid & tready_q;

    assign pipe_in_valid   = accept;
    assign pipe_in_last    = s_axis_tlast;
    assign pipe_in_data    = s_axis_tdata;

    assign fifo_empty      = (wr_ptr == rd_ptr);
    assign fifo_full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_axis_tvalid   = !fifo_empty;
    assign rd_en           = m_axis_tvalid & m_axis_tready;
    // A read in the same cycle frees the slot the incoming word needs.
    assign wr_en           = pipe_out_valid & (!fifo_full | rd_en);
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

    assign flush_done      = (state == ST_DONE);
    assign pixelInPipeline = (reserved_count != '0);

    always_comb begin
        count_nxt = reserved_count;
        if (accept && !rd_en) begin
            count_nxt = reserved_count + 1'b1;
        end else if (!accept && rd_en && reserved_count != '0) begin
            // Stale post-reset words carry no credit; never wrap below zero.
            count_nxt = reserved_count - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (flush_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (count_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            reserved_count <= '0;
            tready_q       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            reserved_count <= count_nxt;
            // Registered so upstream ready never combinationally follows m_axis_tready.
            tready_q       <= (state_nxt == ST_IDLE) && (count_nxt < CW'(FIFO_DEPTH));
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (pipe_out_valid && fifo_full && !rd_en) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {pipe_out_last, pipe_out_data};
        end
    end

endmodule

// File: tb/tb_pixel_pipeline_credit_ctrl.sv
// tb/tb_pixel_pipeline_credit_ctrl.sv - bench for pixel_pipeline_credit_ctrl
module tb_pixel_pipeline_credit_ctrl;

    localparam int DW    = 32;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          p_in_v, p_in_l;
    logic [DW-1:0] p_in_d;
    logic          p_out_v, p_out_l;
    logic [DW-1:0] p_out_d;
    logic          m_tvalid, m_tready = 1'b0, m_tlast;
    logic [DW-1:0] m_tdata;
    logic          flush_req = 1'b0, flush_done, pip, ovf;
    logic [CW-1:0] rcount;
    logic          inj_v = 1'b0, inj_l = 1'b0;
    logic [DW-1:0] inj_d = '0;

    logic [LAT-1:0] pv = '0;
    logic [DW:0]    pd [LAT];

    pixel_pipeline_credit_ctrl #(.DATA_WIDTH(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata),
        .pipe_in_valid(p_in_v), .pipe_in_last(p_in_l), .pipe_in_data(p_in_d),
        .pipe_out_valid(p_out_v), .pipe_out_last(p_out_l), .pipe_out_data(p_out_d),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdata(m_tdata),
        .flush_req(flush_req), .flush_done(flush_done), .pixelInPipeline(pip),
        .reserved_count(rcount), .overflow_err(ovf)
    );

    always #5 aclk = ~aclk;

    // Attached pipeline: a plain LAT-stage delay line, with an injection override.
    always @(posedge aclk) begin
        pv    <= {pv[LAT-2:0], p_in_v};
        pd[0] <= {p_in_l, p_in_d};
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign p_out_v = inj_v | pv[LAT-1];
    assign {p_out_l, p_out_d} = inj_v ? {inj_l, inj_d} : pd[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            vis;
    } word_t;

    word_t         q[$];
    int            mcnt;
    bit            model_on;
    int            cyc;
    int            n_acc, n_dq;
    int            acc_cyc[$];
    int            dq_cyc[$];
    int            fd_cyc[$];
    logic [DW-1:0] out_q[$];

    // One cycle: sample mid-cycle, compare against the queue model, then advance to the next negedge.
    task automatic run_cycle();
        logic acc, dq;
        #1;
        acc = s_tvalid && s_tready;
        dq  = m_tvalid && m_tready;
        if (model_on) begin
            check("m_tvalid", m_tvalid, q.size() > 0 && q[0].vis <= cyc);
            if (m_tvalid && q.size() > 0) begin
                check("m_tdata", m_tdata, q[0].d);
                check("m_tlast", m_tlast, q[0].l);
            end
            check("reserved_count", rcount, mcnt);
            check("s_tready", s_tready, mcnt < DEPTH);
            check("pixelInPipeline", pip, mcnt != 0);
            check("pipe_in_valid", p_in_v, s_tvalid && (mcnt < DEPTH));
            check("overflow_err", ovf, 0);
        end
        if (acc) begin
            q.push_back('{s_tdata, s_tlast, cyc + LAT + 1});
            mcnt++;
            n_acc++;
            acc_cyc.push_back(cyc);
        end
        if (dq) begin
            if (q.size() > 0) void'(q.pop_front());
            if (mcnt > 0) mcnt--;
            n_dq++;
            dq_cyc.push_back(cyc);
            out_q.push_back(m_tdata);
        end
        if (flush_done) fd_cyc.push_back(cyc);
        @(negedge aclk);
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0;
        m_tready = 0; flush_req = 0; inj_v = 0; model_on = 0;
        repeat (LAT + 2) run_cycle();
        q.delete(); acc_cyc.delete(); dq_cyc.delete(); fd_cyc.delete(); out_q.delete();
        mcnt = 0; n_acc = 0; n_dq = 0;
        resetn = 1;
        #1 check("tready_before_first_edge", s_tready, 0);
        @(negedge aclk);
        cyc++;
        check("tready_after_first_edge", s_tready, 1);
    endtask

    typedef struct {
        logic          sv, sl;
        logic [DW-1:0] sd;
        logic          mr, fr;
        logic          e_sr, e_mv, e_ml, e_fd;
        logic [DW-1:0] e_md;
        int            e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic sl, input logic [DW-1:0] sd,
                                input logic mr, input logic fr, input logic e_sr, input logic e_mv,
                                input logic [DW-1:0] e_md, input logic e_ml, input int e_cnt,
                                input logic e_fd);
        vec_t v;
        v.sv = sv; v.sl = sl; v.sd = sd; v.mr = mr; v.fr = fr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_cnt = e_cnt; v.e_fd = e_fd;
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        int fc;
        logic [DW-1:0] a1, a2, b0, b1;
        a1 = 32'h1111_0001; a2 = 32'h1111_0002; b0 = 32'hBBBB_0000; b1 = 32'hBBBB_0001;
        //          sv    sl    sd  mr    fr    e_sr  e_mv  e_md e_ml cnt e_fd
        tbl[0] = mk(1'b1, 1'b0, a1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        tbl[1] = mk(1'b1, 1'b1, a2, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1, 1'b0);
        tbl[2] = mk(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2, 1'b0);
        tbl[3] = mk(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 2, 1'b0);
        tbl[4] = mk(1'b1, 1'b0, b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 2, 1'b0);
        tbl[5] = mk(1'b1, 1'b0, b0, 1'b1, 1'b1, 1'b0, 1'b1, a1, 1'b0, 2, 1'b0);
        tbl[6] = mk(1'b1, 1'b0, b0, 1'b1, 1'b0, 1'b0, 1'b1, a2, 1'b1, 1, 1'b0);
        tbl[7] = mk(1'b1, 1'b0, b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 1'b1);
        tbl[8] = mk(1'b1, 1'b1, b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        tbl[9] = mk(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1, 1'b0);

        cyc = 0;
        @(negedge aclk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_count", rcount, 0);
        check("rst_pip", pip, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_overflow", ovf, 0);
        check("rst_pipe_in_valid", p_in_v, 0);
        @(negedge aclk);

        // Table: short stream, flush during traffic, flush_req ignored in DRAIN.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            s_tvalid = tbl[i].sv; s_tlast = tbl[i].sl; s_tdata = tbl[i].sd;
            m_tready = tbl[i].mr; flush_req = tbl[i].fr;
            #1;
            check($sformatf("tbl%0d_s_tready", i), s_tready, tbl[i].e_sr);
            check($sformatf("tbl%0d_pipe_in_valid", i), p_in_v, tbl[i].sv & tbl[i].e_sr);
            check($sformatf("tbl%0d_m_tvalid", i), m_tvalid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                check($sformatf("tbl%0d_m_tdata", i), m_tdata, tbl[i].e_md);
                check($sformatf("tbl%0d_m_tlast", i), m_tlast, tbl[i].e_ml);
            end
            check($sformatf("tbl%0d_count", i), rcount, tbl[i].e_cnt);
            check($sformatf("tbl%0d_flush_done", i), flush_done, tbl[i].e_fd);
            @(negedge aclk);
            cyc++;
        end
        flush_req = 0;

        // 20-word stream at full rate.
        do_reset();
        model_on = 1; m_tready = 1;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1; s_tdata = 32'hA000_0000 + i; s_tlast = (i == 9 || i == 19);
            run_cycle();
        end
        s_tvalid = 0;
        for (int i = 0; i < 30 && q.size() > 0; i++) run_cycle();
        check("stream_accepts", n_acc, 20);
        check("stream_delivered", n_dq, 20);
        if (acc_cyc.size() == 20 && dq_cyc.size() == 20) begin
            check("stream_first_latency", dq_cyc[0] - acc_cyc[0], 5);
            check("stream_span", dq_cyc[19] - dq_cyc[0], 19);
        end

        // Backpressure until credits run out, then drain.
        do_reset();
        model_on = 1; m_tready = 0;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1; s_tdata = 32'hC000_0000 + i; s_tlast = i[0];
            run_cycle();
        end
        check("bp_accepts", n_acc, DEPTH);
        check("bp_s_tready", s_tready, 0);
        check("bp_count", rcount, DEPTH);
        s_tvalid = 0; m_tready = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) run_cycle();
        check("bp_delivered", n_dq, DEPTH);
        check("bp_count_final", rcount, 0);
        check("bp_pip_final", pip, 0);

        // Full FIFO: pipe write and downstream read in the same cycle.
        do_reset();
        m_tready = 0;
        for (int i = 0; i < 14; i++) begin
            s_tvalid = 1; s_tdata = 32'hD000_0000 + i; run_cycle();
        end
        s_tvalid = 0;
        m_tready = 1; inj_v = 1; inj_d = 32'hDEAD_0008; inj_l = 1;
        run_cycle();
        inj_v = 0;
        for (int i = 0; i < 12; i++) run_cycle();
        check("fullrw_overflow", ovf, 0);
        check("fullrw_count_out", out_q.size(), 9);
        if (out_q.size() == 9) begin
            for (int i = 0; i < 8; i++) check($sformatf("fullrw_word%0d", i), out_q[i], 32'hD000_0000 + i);
            check("fullrw_word8", out_q[8], 32'hDEAD_0008);
        end

        // Flush with 3 words in flight.
        do_reset();
        m_tready = 1;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1; s_tdata = 32'hE000_0000 + i; run_cycle();
        end
        s_tvalid = 0; flush_req = 1; fc = cyc;
        run_cycle();
        flush_req = 0; s_tvalid = 1; s_tdata = 32'hE000_00FF;
        check("flush_tready_low", s_tready, 0);
        for (int i = 0; i < 30 && !(fd_cyc.size() > 0 && cyc > fd_cyc[0] + 2); i++) run_cycle();
        s_tvalid = 0;
        check("flush_done_pulses", fd_cyc.size(), 1);
        check("flush_delivered", dq_cyc.size(), 3);
        if (fd_cyc.size() == 1 && dq_cyc.size() == 3 && acc_cyc.size() >= 4) begin
            check("flush_done_timing", fd_cyc[0] - dq_cyc[2], 1);
            check("flush_no_accept_in_drain", acc_cyc[2] < fc, 1);
            check("flush_reaccept", acc_cyc[3] - fd_cyc[0], 1);
        end else begin
            check("flush_sequence_complete", 0, 1);
        end

        // Asynchronous reset with 5 words in the FIFO.
        do_reset();
        m_tready = 0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1; s_tdata = 32'hF000_0000 + i; run_cycle();
        end
        s_tvalid = 0;
        repeat (6) run_cycle();
        check("pre_rst_m_tvalid", m_tvalid, 1);
        check("pre_rst_count", rcount, 5);
        s_tvalid = 1;
        #2 resetn = 0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 0);
        check("async_rst_count", rcount, 0);
        check("async_rst_pip", pip, 0);
        check("async_rst_s_tready", s_tready, 0);
        check("async_rst_pipe_in_valid", p_in_v, 0);
        @(negedge aclk);
        cyc++;

        // Overflow: forced pipe output into a full FIFO with no read.
        do_reset();
        m_tready = 0;
        for (int i = 0; i < 14; i++) begin
            s_tvalid = 1; s_tdata = 32'h7000_0000 + i; run_cycle();
        end
        s_tvalid = 0;
        check("ovf_before", ovf, 0);
        inj_v = 1; inj_d = 32'hBAD0_0000; inj_l = 0;
        run_cycle();
        inj_v = 0;
        check("ovf_set", ovf, 1);
        m_tready = 1;
        repeat (12) run_cycle();
        check("ovf_sticky", ovf, 1);
        check("ovf_dropped_count", out_q.size(), 8);
        if (out_q.size() == 8) check("ovf_last_word", out_q[7], 32'h7000_0007);
        do_reset();
        check("ovf_cleared", ovf, 0);

        // Random traffic against the queue model.
        model_on = 1;
        for (int i = 0; i < 400; i++) begin
            s_tvalid = ($urandom % 4) != 0;
            s_tdata  = $urandom;
            s_tlast  = $urandom % 2;
            m_tready = (i % 64 < 20) ? 1'b0 : (($urandom % 3) != 0);
            run_cycle();
        end
        s_tvalid = 0; m_tready = 1;
        for (int i = 0; i < 40 && q.size() > 0; i++) run_cycle();
        check("rand_model_empty", q.size(), 0);
        check("rand_final_count", rcount, 0);
        check("rand_accounting", n_acc, n_dq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
